// File: rtl/lcd8080_pkg.sv
// Shared types and 50 MHz default timing for the lcd8080 MCU-8080 write engine.
// Optional read path is enabled with the LCD_READ_EN macro.
package lcd8080_pkg;

    typedef enum logic [3:0] {
        RST_LOW,
        RST_WAIT,
        IDLE,
        SETUP,
        WR_LO,
        WR_HI,
        HOLD
`ifdef LCD_READ_EN
        ,
        RD_LO,
        RD_HI
`endif
    } lcd_state_e;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FIFO_DEPTH   = 8;
    localparam int DEF_WR_LOW_CYC   = 2;
    localparam int DEF_WR_HIGH_CYC  = 2;
    localparam int DEF_RST_LOW_CYC  = 500;      // 10 us
    localparam int DEF_RST_WAIT_CYC = 6000000;  // 120 ms
    localparam int DEF_CS_IDLE_CYC  = 4;

    // Width of one shared phase counter able to hold the largest phase length.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/lcd8080_fifo.sv
// Synchronous FIFO holding {dc, data} beats; power-of-two depth, no bypass path.
module lcd8080_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; count/pointers alone define which entries are valid.
    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd8080_bus_ctrl.sv
// MCU-8080 parallel write engine for ILI9341-class panels: reset sequencing, FIFO, CS framing.
// Define LCD_READ_EN to add the single-beat read path (rd_req/rd_valid/rd_data).
module lcd8080_bus_ctrl
    import lcd8080_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int WR_LOW_CYC   = DEF_WR_LOW_CYC,
    parameter int WR_HIGH_CYC  = DEF_WR_HIGH_CYC,
    parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
    parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC,
    parameter int CS_IDLE_CYC  = DEF_CS_IDLE_CYC
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dc,
    input  logic [DATA_W-1:0] in_data,
    output logic              init_done,
    output logic              busy,
    output logic              csx,
    output logic              resx,
    output logic              dcx,
    output logic              wrx,
    output logic              rdx,
    output logic [DATA_W-1:0] db_out,
    output logic              db_oe
`ifdef LCD_READ_EN
    ,
    input  logic              rd_req,
    input  logic              rd_dc,
    input  logic [DATA_W-1:0] db_in,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
`endif
);

    localparam int CNT_W = cnt_width(RST_LOW_CYC, RST_WAIT_CYC, WR_LOW_CYC + 2,
                                     WR_HIGH_CYC, CS_IDLE_CYC);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LOW_LAST   = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WR_HIGH_LAST  = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CS_IDLE_LAST  = CNT_W'(CS_IDLE_CYC - 1);
`ifdef LCD_READ_EN
    localparam logic [CNT_W-1:0] RD_LOW_LAST   = CNT_W'(WR_LOW_CYC + 1);
`endif

    lcd_state_e        state, next_state;
    logic [CNT_W-1:0]  cnt, next_cnt;
    logic              fifo_push, fifo_pop, load_head;
    logic [DATA_W:0]   fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;
    logic              csx_d, resx_d, wrx_d, db_oe_d;
`ifdef LCD_READ_EN
    logic              rd_start, rd_sample, rd_op, rd_op_next, rdx_d;
`endif

    assign init_done = !(state == RST_LOW || state == RST_WAIT);
    assign in_ready  = init_done && !fifo_full;
    assign fifo_push = in_valid && in_ready;

`ifdef LCD_READ_EN
    assign busy = (fifo_count != '0) ||
                  (state inside {SETUP, WR_LO, WR_HI, RD_LO, RD_HI});
`else
    assign busy = (fifo_count != '0) || (state inside {SETUP, WR_LO, WR_HI});
    assign rdx  = 1'b1;
`endif

    lcd8080_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      ({in_dc, in_data}),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = cnt + 1'b1;
        fifo_pop   = 1'b0;
        load_head  = 1'b0;
`ifdef LCD_READ_EN
        rd_start   = 1'b0;
        rd_sample  = 1'b0;
`endif
        case (state)
            RST_LOW:  if (cnt == RST_LOW_LAST)  next_state = RST_WAIT;
            RST_WAIT: if (cnt == RST_WAIT_LAST) next_state = IDLE;
            IDLE: begin
                next_cnt = '0;
                if (!fifo_empty) begin
                    next_state = SETUP;
                    load_head  = 1'b1;
                end
`ifdef LCD_READ_EN
                else if (rd_req) begin
                    next_state = SETUP;
                    rd_start   = 1'b1;
                end
`endif
            end
            SETUP: begin
`ifdef LCD_READ_EN
                if (rd_op) next_state = RD_LO;
                else
`endif
                begin
                    fifo_pop   = 1'b1;
                    next_state = WR_LO;
                end
            end
            WR_LO: if (cnt == WR_LOW_LAST) next_state = WR_HI;
            WR_HI: begin
                if (cnt == WR_HIGH_LAST) begin
                    // Chain straight into the next strobe while beats are queued.
                    if (!fifo_empty) begin
                        next_state = WR_LO;
                        load_head  = 1'b1;
                        fifo_pop   = 1'b1;
                    end else begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!fifo_empty) begin
                    next_state = SETUP;
                    load_head  = 1'b1;
                end
`ifdef LCD_READ_EN
                else if (rd_req) begin
                    next_state = SETUP;
                    rd_start   = 1'b1;
                end
`endif
                else if (cnt == CS_IDLE_LAST) begin
                    next_state = IDLE;
                end
            end
`ifdef LCD_READ_EN
            RD_LO: begin
                if (cnt == RD_LOW_LAST) begin
                    next_state = RD_HI;
                    rd_sample  = 1'b1;
                end
            end
            RD_HI: begin
                if (cnt == WR_HIGH_LAST) begin
                    if (!fifo_empty) begin
                        next_state = SETUP;
                        load_head  = 1'b1;
                    end else begin
                        next_state = HOLD;
                    end
                end
            end
`endif
            default: next_state = RST_LOW;
        endcase

        if (next_state != state) next_cnt = '0;

        // Pins are registered from the next state so they never glitch.
        csx_d   = next_state inside {RST_LOW, RST_WAIT, IDLE};
        resx_d  = (next_state != RST_LOW);
        wrx_d   = (next_state != WR_LO);
        db_oe_d = next_state inside {SETUP, WR_LO, WR_HI, HOLD};
`ifdef LCD_READ_EN
        rd_op_next = rd_start || (rd_op && !load_head);
        rdx_d      = (next_state != RD_LO);
        if (rd_op_next) db_oe_d = 1'b0;
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= RST_LOW;
            cnt    <= '0;
            csx    <= 1'b1;
            resx   <= 1'b0;
            wrx    <= 1'b1;
            db_oe  <= 1'b0;
            dcx    <= LCD_CMD;
            db_out <= '0;
`ifdef LCD_READ_EN
            rdx      <= 1'b1;
            rd_op    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
`endif
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            csx   <= csx_d;
            resx  <= resx_d;
            wrx   <= wrx_d;
            db_oe <= db_oe_d;
            if (load_head) begin
                dcx    <= fifo_dout[DATA_W];
                db_out <= fifo_dout[DATA_W-1:0];
            end
`ifdef LCD_READ_EN
            if (rd_start) dcx <= rd_dc;
            rdx      <= rdx_d;
            rd_op    <= rd_op_next;
            rd_valid <= rd_sample;
            if (rd_sample) rd_data <= db_in;
`endif
        end
    end

endmodule

// File: tb/tb_lcd8080_bus_ctrl.sv
// Directed bench for lcd8080_bus_ctrl: reset sequence, single command, burst, backpressure, abort.
module tb_lcd8080_bus_ctrl;
    import lcd8080_pkg::*;

    localparam int DATA_W = 8;

    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_dc    = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_ready, init_done, busy, csx, resx, dcx, wrx, rdx, db_oe;
    logic [DATA_W-1:0] db_out;
`ifdef LCD_READ_EN
    logic              rd_req = 1'b0;
    logic              rd_dc  = 1'b0;
    logic [DATA_W-1:0] db_in  = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    lcd8080_bus_ctrl #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (8),
        .WR_LOW_CYC   (2),
        .WR_HIGH_CYC  (2),
        .RST_LOW_CYC  (5),
        .RST_WAIT_CYC (10),
        .CS_IDLE_CYC  (4)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dc     (in_dc),
        .in_data   (in_data),
        .init_done (init_done),
        .busy      (busy),
        .csx       (csx),
        .resx      (resx),
        .dcx       (dcx),
        .wrx       (wrx),
        .rdx       (rdx),
        .db_out    (db_out),
        .db_oe     (db_oe)
`ifdef LCD_READ_EN
        ,
        .rd_req    (rd_req),
        .rd_dc     (rd_dc),
        .db_in     (db_in),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
`endif
    );

    // Panel-side monitor: records what is on the bus at every completed wrx rising edge.
    logic [DATA_W-1:0] mon_data [$];
    logic              mon_dc   [$];
    logic              mon_csx  [$];
    int                mon_cyc  [$];
    int                cyc      = 0;
    logic              wrx_prev = 1'b1;

    always @(negedge CLOCK_50) begin
        if (resx === 1'b1 && wrx_prev === 1'b0 && wrx === 1'b1) begin
            mon_data.push_back(db_out);
            mon_dc.push_back(dcx);
            mon_csx.push_back(csx);
            mon_cyc.push_back(cyc);
        end
        wrx_prev <= wrx;
        cyc      <= cyc + 1;
    end

    logic [DATA_W-1:0] exp_data [$];
    logic              exp_dc   [$];

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_logs;
        mon_data.delete(); mon_dc.delete(); mon_csx.delete(); mon_cyc.delete();
        exp_data.delete(); exp_dc.delete();
    endtask

    task automatic push_beat(input logic dc, input logic [DATA_W-1:0] data, output int waited);
        in_valid = 1'b1;
        in_dc    = dc;
        in_data  = data;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            tick;
            waited++;
        end
        if (waited >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready never rose for data 0x%0h", data);
        end else begin
            exp_data.push_back(data);
            exp_dc.push_back(dc);
        end
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (csx !== 1'b1 && n < 200) begin tick; n++; end
        checks++;
        if (csx !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: csx=%b required 1 within 200 clocks", name, csx);
        end
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        tick;
        checks++;
        if ({csx, resx, dcx, wrx, rdx, db_oe, init_done, busy, in_ready} !== 9'b1_0_0_1_1_0_0_0_0) begin
            errors++;
            $display("FAIL reset_pins: {csx,resx,dcx,wrx,rdx,oe,init,busy,rdy}=%b required 100110000",
                     {csx, resx, dcx, wrx, rdx, db_oe, init_done, busy, in_ready});
        end
        checks++;
        if (db_out !== '0) begin
            errors++;
            $display("FAIL reset_db_out: got 0x%0h required 0x0", db_out);
        end
        tick;
        reset = 1'b0;
        n = 0;
        while (resx === 1'b0 && n < 100) begin n++; tick; end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL resx_low_len: resx low for %0d clocks required 5", n);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin n++; tick; end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL rst_wait_len: init_done after %0d clocks required 10", n);
        end
        checks++;
        if (in_ready !== 1'b1 || resx !== 1'b1) begin
            errors++;
            $display("FAIL init_ready: in_ready=%b resx=%b required 1 1", in_ready, resx);
        end
    endtask

    task automatic test_single_cmd;
        int w;
        // {csx, wrx, db_oe, busy}: SETUP, WR_LO x2, WR_HI x2, HOLD x4, IDLE
        logic [3:0] tbl [10] = '{4'b0111, 4'b0011, 4'b0011, 4'b0111, 4'b0111,
                                 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b1100};
        clear_logs();
        push_beat(LCD_CMD, 8'h2C, w);
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if ({csx, wrx, db_oe, busy} !== tbl[i]) begin
                errors++;
                $display("FAIL single_step%0d: {csx,wrx,oe,busy}=%b required %b",
                         i, {csx, wrx, db_oe, busy}, tbl[i]);
            end
            if (i == 0) begin
                checks++;
                if (dcx !== LCD_CMD || db_out !== 8'h2C) begin
                    errors++;
                    $display("FAIL single_setup_bus: dcx=%b db_out=0x%0h required 0 0x2c", dcx, db_out);
                end
            end
        end
        checks++;
        if (mon_data.size() !== 1 || mon_data[0] !== 8'h2C || mon_dc[0] !== LCD_CMD || mon_csx[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: %0d beats latched, first 0x%0h required one beat 0x2c dc=0 csx=0",
                     mon_data.size(), mon_data.size() > 0 ? mon_data[0] : 8'h0);
        end
    endtask

    task automatic test_burst;
        int w, n;
        clear_logs();
        for (int i = 0; i < 8; i++) push_beat(LCD_DATA, DATA_W'(i), w);
        n = 0;
        while (mon_data.size() < 8 && n < 200) begin tick; n++; end
        checks++;
        if (mon_data.size() !== 8) begin
            errors++;
            $display("FAIL burst_count: %0d beats latched required 8", mon_data.size());
        end
        for (int i = 0; i < mon_data.size() && i < 8; i++) begin
            checks++;
            if (mon_data[i] !== DATA_W'(i) || mon_dc[i] !== LCD_DATA || mon_csx[i] !== 1'b0) begin
                errors++;
                $display("FAIL burst_beat%0d: data=0x%0h dc=%b csx=%b required 0x%0h 1 0",
                         i, mon_data[i], mon_dc[i], mon_csx[i], i);
            end
            if (i > 0) begin
                checks++;
                if (mon_cyc[i] - mon_cyc[i-1] !== 4) begin
                    errors++;
                    $display("FAIL burst_spacing%0d: %0d clocks between wrx rises required 4",
                             i, mon_cyc[i] - mon_cyc[i-1]);
                end
            end
        end
        wait_idle("burst");
    endtask

    task automatic test_backpressure;
        int w, n, first_stall;
        clear_logs();
        first_stall = -1;
        for (int i = 0; i < 10; i++) begin
            push_beat(i[0], DATA_W'(8'h40 + i), w);
            if (w > 0 && first_stall < 0) first_stall = i;
        end
        // Starting idle, pops land every 4 clocks from the 3rd, so the 11th beat meets a full FIFO.
        push_beat(1'b1, 8'h4A, w);
        if (w > 0 && first_stall < 0) first_stall = 10;
        push_beat(1'b0, 8'h4B, w);
        checks++;
        if (first_stall !== 10) begin
            errors++;
            $display("FAIL bp_first_stall: first stalled beat %0d required 10", first_stall);
        end
        n = 0;
        while (n < 100) begin tick; n++; end
        checks++;
        if (mon_data.size() !== 12) begin
            errors++;
            $display("FAIL bp_count: %0d beats latched required 12", mon_data.size());
        end
        for (int i = 0; i < mon_data.size() && i < 12; i++) begin
            checks++;
            if (mon_data[i] !== exp_data[i] || mon_dc[i] !== exp_dc[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: data=0x%0h dc=%b required 0x%0h %b",
                         i, mon_data[i], mon_dc[i], exp_data[i], exp_dc[i]);
            end
        end
        wait_idle("bp");
    endtask

    task automatic test_reset_mid_beat;
        int w, n;
        clear_logs();
        for (int i = 0; i < 5; i++) push_beat(LCD_DATA, DATA_W'(8'h80 + i), w);
        n = 0;
        while (mon_data.size() < 2 && n < 100) begin tick; n++; end
        tick;
        checks++;
        if (wrx !== 1'b0 || mon_data.size() !== 2) begin
            errors++;
            $display("FAIL abort_setup: wrx=%b beats=%0d required 0 2", wrx, mon_data.size());
        end
        reset = 1'b1;
        tick;
        checks++;
        if ({wrx, csx, resx, db_oe, busy, in_ready} !== 6'b110000) begin
            errors++;
            $display("FAIL abort_pins: {wrx,csx,resx,oe,busy,rdy}=%b required 110000",
                     {wrx, csx, resx, db_oe, busy, in_ready});
        end
        reset = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin tick; n++; end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL abort_reinit: init_done=%b required 1", init_done);
        end
        for (int i = 0; i < 20; i++) tick;
        checks++;
        if (mon_data.size() !== 2 || busy !== 1'b0 || csx !== 1'b1) begin
            errors++;
            $display("FAIL abort_flush: beats=%0d busy=%b csx=%b required 2 0 1",
                     mon_data.size(), busy, csx);
        end
    endtask

`ifdef LCD_READ_EN
    task automatic test_read;
        int lows = 0;
        int pulses = 0;
        logic [DATA_W-1:0] got = '0;
        wait_idle("read");
        rd_dc  = 1'b1;
        db_in  = 8'hA5;
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (rdx === 1'b0) lows++;
            if (rd_valid === 1'b1) begin pulses++; got = rd_data; end
        end
        checks++;
        if (lows !== 4) begin
            errors++;
            $display("FAIL read_rdx_low: rdx low %0d clocks required 4", lows);
        end
        checks++;
        if (pulses !== 1 || got !== 8'hA5) begin
            errors++;
            $display("FAIL read_data: %0d pulses data 0x%0h required 1 0xa5", pulses, got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_cmd();
        test_burst();
        test_backpressure();
`ifdef LCD_READ_EN
        test_read();
`endif
        test_reset_mid_beat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
